// File: rtl/multicycle_main_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: opcodes, FSM states,
// ALU op / operand select codes and the bundled control-output record.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEMACC = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic       mem_to_reg;
        logic       retire;
        logic       fault;
    } ctrl_out_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_ctrl_if.sv
// Controller <-> datapath/memory bundle: decode inputs, handshake and all control strobes.
interface multicycle_main_ctrl_if;

    logic [6:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic       mem_to_reg;
    logic       retire;
    logic       fault;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_we, mem_to_reg, retire, fault
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_we, mem_to_reg, retire, fault
    );

endinterface

// File: rtl/multicycle_main_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags that the wait limit is reached.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [7:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired = (r_count == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences FETCH/DECODE/EXEC/MEMACC/WB
// over a shared ALU and memory port, with a bounded wait on the memory handshake.
module multicycle_main_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_main_ctrl_if.master bus
);

    state_t     r_state;
    logic [6:0] r_op_q;
    ctrl_out_t  w_out;
    logic       w_waiting;
    logic       w_run;
    logic       w_expired;

    // The counter only advances while a memory request is outstanding and unanswered;
    // holding it clear elsewhere means it is already zero on entry to FETCH/MEMACC.
    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEMACC);
    assign w_run     = w_waiting && !bus.mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!w_run),
        .run     (w_run),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
            r_op_q  <= '0;
        end else begin
            case (r_state)
                ST_RST:    r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.mem_ready)  r_state <= ST_DECODE;
                    else if (w_expired) r_state <= ST_FAULT;
                end
                ST_DECODE: begin
                    r_op_q  <= bus.opcode;
                    r_state <= is_legal_op(bus.opcode) ? ST_EXEC : ST_FAULT;
                end
                ST_EXEC: begin
                    case (r_op_q)
                        OP_R, OP_IMM:      r_state <= ST_WB;
                        OP_LOAD, OP_STORE: r_state <= ST_MEMACC;
                        default:           r_state <= ST_FETCH;
                    endcase
                end
                ST_MEMACC: begin
                    if (bus.mem_ready)  r_state <= (r_op_q == OP_STORE) ? ST_FETCH : ST_WB;
                    else if (w_expired) r_state <= ST_FAULT;
                end
                ST_WB:     r_state <= ST_FETCH;
                default:   r_state <= ST_FAULT;
            endcase
        end
    end

    // NOTE: w_out gets a full default before the case so no output can infer a latch.
    always_comb begin
        w_out = '0;
        case (r_state)
            ST_FETCH: begin
                w_out.mem_req   = 1'b1;
                w_out.alu_src_a = SRCA_PC;
                w_out.alu_src_b = SRCB_FOUR;
                w_out.alu_op    = ALUOP_ADD;
                w_out.ir_we     = bus.mem_ready;
                w_out.pc_we     = bus.mem_ready;
            end
            ST_DECODE: begin
                w_out.alu_src_a = SRCA_OLDPC;
                w_out.alu_src_b = SRCB_IMM;
                w_out.alu_op    = ALUOP_ADD;
            end
            ST_EXEC: begin
                w_out.alu_src_a = SRCA_RS1;
                case (r_op_q)
                    OP_R: begin
                        w_out.alu_src_b = SRCB_RS2;
                        w_out.alu_op    = ALUOP_FUNCT;
                    end
                    OP_BRANCH: begin
                        w_out.alu_src_b = SRCB_RS2;
                        w_out.alu_op    = ALUOP_SUB;
                        w_out.pc_we     = bus.alu_zero;
                        w_out.pc_src    = 1'b1;
                        w_out.retire    = 1'b1;
                    end
                    // ADDI must not use funct decoding: Inst[30] is an immediate bit there.
                    default: begin
                        w_out.alu_src_b = SRCB_IMM;
                        w_out.alu_op    = ALUOP_ADD;
                    end
                endcase
            end
            ST_MEMACC: begin
                w_out.mem_req = 1'b1;
                w_out.iord    = 1'b1;
                w_out.mem_we  = (r_op_q == OP_STORE);
                w_out.retire  = bus.mem_ready && (r_op_q == OP_STORE);
            end
            ST_WB: begin
                w_out.reg_we     = 1'b1;
                w_out.mem_to_reg = (r_op_q == OP_LOAD);
                w_out.retire     = 1'b1;
            end
            ST_FAULT: w_out.fault = 1'b1;
            default:  w_out = '0;
        endcase
    end

    assign bus.mem_req    = w_out.mem_req;
    assign bus.mem_we     = w_out.mem_we;
    assign bus.iord       = w_out.iord;
    assign bus.ir_we      = w_out.ir_we;
    assign bus.pc_we      = w_out.pc_we;
    assign bus.pc_src     = w_out.pc_src;
    assign bus.alu_src_a  = w_out.alu_src_a;
    assign bus.alu_src_b  = w_out.alu_src_b;
    assign bus.alu_op     = w_out.alu_op;
    assign bus.reg_we     = w_out.reg_we;
    assign bus.mem_to_reg = w_out.mem_to_reg;
    assign bus.retire     = w_out.retire;
    assign bus.fault      = w_out.fault;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Self-checking bench for multicycle_main_ctrl: an instruction-step model checked every
// cycle, plus directed scenarios with hand-computed cycle counts and strobe values.
module tb_multicycle_main_ctrl;

    localparam int TMO = 4;
    localparam logic [6:0] I_R    = 7'b0110011;
    localparam logic [6:0] I_ADDI = 7'b0010011;
    localparam logic [6:0] I_LW   = 7'b0000011;
    localparam logic [6:0] I_SW   = 7'b0100011;
    localparam logic [6:0] I_BEQ  = 7'b1100011;
    localparam logic [6:0] I_JAL  = 7'b1101111;

    typedef struct packed {
        logic       req, we, iord, ir, pcwe, pcsrc;
        logic [1:0] a, b, aop;
        logic       rw, m2r, ret, flt;
    } obs_t;

    typedef enum {M_IDLE, M_FETCH, M_DEC, M_EXE, M_MEM, M_WB, M_DEAD} mstep_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   wr_commit = 0;

    always #5 clk = ~clk;

    multicycle_main_ctrl_if bus ();

    multicycle_main_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = '{bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.pc_src,
              bus.alu_src_a, bus.alu_src_b, bus.alu_op,
              bus.reg_we, bus.mem_to_reg, bus.retire, bus.fault};
        return o;
    endfunction

    // ---------------- behavioural model: which step of which instruction we are in
    mstep_t     m_step = M_IDLE;
    int         m_wait = 0;
    logic [6:0] m_op = '0;

    function automatic logic legal(input logic [6:0] op);
        return (op == I_R) || (op == I_ADDI) || (op == I_LW) || (op == I_SW) || (op == I_BEQ);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step <= M_IDLE;
            m_wait <= 0;
        end else begin
            case (m_step)
                M_IDLE:  begin m_step <= M_FETCH; m_wait <= 0; end
                M_FETCH, M_MEM: begin
                    if (bus.mem_ready) begin
                        if (m_step == M_FETCH)  m_step <= M_DEC;
                        else if (m_op == I_SW)  begin m_step <= M_FETCH; m_wait <= 0; end
                        else                    m_step <= M_WB;
                    end else if (m_wait == TMO) m_step <= M_DEAD;
                    else                        m_wait <= m_wait + 1;
                end
                M_DEC: begin
                    m_op   <= bus.opcode;
                    m_step <= legal(bus.opcode) ? M_EXE : M_DEAD;
                end
                M_EXE: begin
                    m_wait <= 0;
                    if (m_op == I_R || m_op == I_ADDI)     m_step <= M_WB;
                    else if (m_op == I_LW || m_op == I_SW) m_step <= M_MEM;
                    else                                   m_step <= M_FETCH;
                end
                M_WB:    begin m_step <= M_FETCH; m_wait <= 0; end
                default: m_step <= M_DEAD;
            endcase
        end
    end

    function automatic obs_t model_outs(input mstep_t s, input logic [6:0] op,
                                        input logic rdy, input logic z);
        obs_t e;
        e = '0;
        case (s)
            M_FETCH: begin e.req = 1; e.b = 2'd1; e.ir = rdy; e.pcwe = rdy; end
            M_DEC:   begin e.a = 2'd2; e.b = 2'd2; end
            M_EXE: begin
                e.a = 2'd1;
                if (op == I_R)        e.aop = 2'b10;
                else if (op == I_BEQ) begin e.aop = 2'b01; e.pcwe = z; e.pcsrc = 1; e.ret = 1; end
                else                  e.b = 2'd2;
            end
            M_MEM:  begin e.req = 1; e.iord = 1; e.we = (op == I_SW); e.ret = rdy && (op == I_SW); end
            M_WB:   begin e.rw = 1; e.m2r = (op == I_LW); e.ret = 1; end
            M_DEAD: e.flt = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        check("outputs_vs_model", sample(),
              model_outs(m_step, m_op, bus.mem_ready, bus.alu_zero));
        if (bus.mem_req && bus.mem_we && bus.mem_ready) wr_commit <= wr_commit + 1;
    end

    // ---------------- directed stimulus helpers
    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_cycle(input logic rdy, input logic z, input logic [6:0] op, output obs_t o);
        bus.mem_ready = rdy;
        bus.alu_zero  = z;
        bus.opcode    = op;
        @(negedge clk);
        o = sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        obs_t o;
        int   ret_cyc, ret_cnt, rw_cnt, req_cnt, flt_cnt, base;
        logic [1:0] aop3;
        bus.opcode = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;

        // R-type, zero-wait memory
        do_reset();
        run_cycle(1, 0, I_R, o);
        check("reset_outputs_zero", o, 32'h0);
        ret_cyc = 0; ret_cnt = 0; rw_cnt = 0; aop3 = '0;
        for (int c = 1; c <= 4; c++) begin
            run_cycle(1, 0, I_R, o);
            if (o.ret) begin ret_cnt++; if (ret_cyc == 0) ret_cyc = c; end
            if (o.rw) rw_cnt++;
            if (c == 3) aop3 = o.aop;
        end
        check("r_retire_cycle", ret_cyc, 4);
        check("r_retire_count", ret_cnt, 1);
        check("r_reg_we_count", rw_cnt, 1);
        check("r_exec_alu_op", aop3, 2'b10);
        run_cycle(1, 0, I_R, o);
        check("r_back_to_fetch", o.req, 1);

        // ADDI uses add, not funct decode
        do_reset();
        run_cycle(1, 0, I_ADDI, o);
        for (int c = 1; c <= 3; c++) run_cycle(1, 0, I_ADDI, o);
        check("addi_exec_alu_op_srcb", {o.aop, o.b}, {2'b00, 2'd2});

        // LW with three wait cycles in MEMACC
        do_reset();
        run_cycle(1, 0, I_LW, o);
        ret_cyc = 0; ret_cnt = 0; req_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            run_cycle(!(c >= 4 && c <= 6), 0, I_LW, o);
            if (o.req && o.iord) req_cnt++;
            if (o.ret) begin ret_cnt++; if (ret_cyc == 0) ret_cyc = c; end
            if (c == 8) check("lw_wb_mem_to_reg_reg_we", {o.m2r, o.rw}, 2'b11);
        end
        check("lw_memacc_req_cycles", req_cnt, 4);
        check("lw_retire_cycle", ret_cyc, 8);
        check("lw_retire_count", ret_cnt, 1);

        // BEQ taken and not taken
        for (int t = 0; t < 2; t++) begin
            logic zz;
            zz = (t == 0);
            do_reset();
            run_cycle(1, zz, I_BEQ, o);
            for (int c = 1; c <= 3; c++) run_cycle(1, zz, I_BEQ, o);
            check(zz ? "beq_taken_pcwe_src_ret" : "beq_nottaken_pcwe_src_ret",
                  {o.pcwe, o.pcsrc, o.ret}, {zz, 2'b11});
            run_cycle(1, zz, I_BEQ, o);
            check("beq_back_to_fetch", o.req, 1);
        end

        // Unsupported JAL faults after DECODE and stays faulted
        do_reset();
        run_cycle(1, 0, I_JAL, o);
        run_cycle(1, 0, I_JAL, o);
        run_cycle(1, 0, I_JAL, o);
        req_cnt = 0; flt_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            run_cycle(c[0], 0, I_JAL, o);
            if (o.req) req_cnt++;
            if (o.flt) flt_cnt++;
        end
        check("jal_fault_cycles", flt_cnt, 20);
        check("jal_mem_req_cycles", req_cnt, 0);

        // FETCH timeout at MEM_TIMEOUT=4: decided on the 5th waiting cycle
        do_reset();
        run_cycle(0, 0, I_R, o);
        for (int c = 1; c <= 5; c++) run_cycle(0, 0, I_R, o);
        check("fetch_wait5_still_req_no_fault", {o.req, o.flt}, 2'b10);
        run_cycle(0, 0, I_R, o);
        check("fetch_timeout_fault_no_req", {o.req, o.flt}, 2'b01);

        // Same, but mem_ready arrives on the 5th cycle: completes normally
        do_reset();
        run_cycle(0, 0, I_R, o);
        for (int c = 1; c <= 4; c++) run_cycle(0, 0, I_R, o);
        run_cycle(1, 0, I_R, o);
        check("fetch_ready_on_limit_ir_we", o.ir, 1);
        run_cycle(0, 0, I_R, o);
        check("fetch_ready_on_limit_decode", {o.flt, o.a, o.b}, {1'b0, 2'd2, 2'd2});

        // MEMACC timeout on a store
        do_reset();
        run_cycle(1, 0, I_SW, o);
        for (int c = 1; c <= 8; c++) run_cycle(c == 1, 0, I_SW, o);
        run_cycle(0, 0, I_SW, o);
        check("memacc_timeout_fault", o.flt, 1);

        // Reset asserted mid-MEMACC of SW with mem_ready low
        base = wr_commit;
        do_reset();
        run_cycle(1, 0, I_SW, o);
        for (int c = 1; c <= 4; c++) run_cycle(c == 1, 0, I_SW, o);
        check("sw_memacc_we_visible", {o.req, o.we, o.iord}, 3'b111);
        bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs_zero", sample(), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_cycle(0, 0, I_SW, o);
        check("after_reset_rst_state", o, 32'h0);
        run_cycle(0, 0, I_SW, o);
        check("after_reset_fetch", {o.req, o.iord, o.we}, 3'b100);
        check("no_write_committed", wr_commit - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
